// File: rtl/speck32_round_ctrl.sv
// SPECK32/64 iterative encryption controller.
// One round per clock: the data round and the key-schedule step for that round
// are computed together from the current round counter, so no key expansion
// memory is needed.
//
// state | meaning
// IDLE  | waiting for a request; in_ready high, ct reads 0
// RUN   | executing round round_idx; ct shows the in-progress {x, y}
// DONE  | ciphertext held on ct with out_valid until out_ready
module speck32_round_ctrl #(
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pt,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ct,
  output logic        busy,
  output logic [4:0]  round_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] x, y, k, l0, l1, l2;
  logic [4:0]  cnt;

  logic [15:0] x_ror, y_rol, l0_ror, k_rol;
  logic [15:0] x_nxt, y_nxt, l_new, k_nxt;

  // One SPECK round plus the matching key-schedule step, carries dropped.
  always_comb begin
    x_ror  = (x >> ALPHA) | (x << (16 - ALPHA));
    y_rol  = (y << BETA) | (y >> (16 - BETA));
    l0_ror = (l0 >> ALPHA) | (l0 << (16 - ALPHA));
    k_rol  = (k << BETA) | (k >> (16 - BETA));
    x_nxt  = (x_ror + y) ^ k;
    y_nxt  = y_rol ^ x_nxt;
    l_new  = (k + l0_ror) ^ {11'd0, cnt};
    k_nxt  = k_rol ^ l_new;
  end

  // Controller FSM and datapath registers; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      l0    <= '0;
      l1    <= '0;
      l2    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x     <= pt[31:16];
            y     <= pt[15:0];
            k     <= key[15:0];
            l0    <= key[31:16];
            l1    <= key[47:32];
            l2    <= key[63:48];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          x  <= x_nxt;
          y  <= y_nxt;
          k  <= k_nxt;
          l0 <= l1;
          l1 <= l2;
          l2 <= l_new;
          if (cnt == 5'(ROUNDS - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign round_idx = (state == RUN) ? cnt : 5'd0;
  assign ct        = (state == IDLE) ? 32'd0 : {x, y};

endmodule

// File: tb/tb_speck32_round_ctrl.sv
// Self-checking bench for speck32_round_ctrl against an array-based SPECK32/64 model.
module tb_speck32_round_ctrl;

  localparam int ROUNDS = 22;
  localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
  localparam logic [31:0] KAT_PT  = 32'h6574694C;
  localparam logic [31:0] KAT_CT  = 32'hA86842F2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pt;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ct;
  logic        busy;
  logic [4:0]  round_idx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  speck32_round_ctrl #(.ROUNDS(ROUNDS), .ALPHA(7), .BETA(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pt(pt), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ct(ct), .busy(busy), .round_idx(round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ror(input logic [15:0] v, input int n);
    return 16'((v >> n) | (v << (16 - n)));
  endfunction

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return 16'((v << n) | (v >> (16 - n)));
  endfunction

  // Textbook SPECK32/64: expand all round keys first, then encrypt.
  function automatic logic [31:0] speck_ref(input logic [31:0] p, input logic [63:0] kk);
    logic [15:0] rk [ROUNDS];
    logic [15:0] l  [ROUNDS+3];
    logic [15:0] a, b;
    rk[0] = kk[15:0];
    l[0] = kk[31:16]; l[1] = kk[47:32]; l[2] = kk[63:48];
    for (int i = 0; i < ROUNDS - 1; i++) begin
      l[i+3]  = 16'(rk[i] + ror(l[i], 7)) ^ 16'(i);
      rk[i+1] = rol(rk[i], 2) ^ l[i+3];
    end
    a = p[31:16]; b = p[15:0];
    for (int i = 0; i < ROUNDS; i++) begin
      a = 16'(ror(a, 7) + b) ^ rk[i];
      b = rol(b, 2) ^ a;
    end
    return {a, b};
  endfunction

  // Drives one request and collects its result; lat counts rising edges from the
  // accepting edge up to and including the first edge that sees out_valid high.
  task automatic do_block(input logic [31:0] p, input logic [63:0] kk, input bit rand_ready,
                          output logic [31:0] got, output int lat, output bit tmo);
    bit acc = 0;
    bit ov;
    bit seen = 0;
    got = '0; lat = 0; tmo = 0;
    @(negedge clk);
    in_valid = 1'b1; pt = p; key = kk;
    out_ready = rand_ready ? 1'($urandom) : 1'b1;
    for (int t = 0; t < 60 && !acc; t++) begin
      if (t > 0) @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    if (!acc) begin tmo = 1; in_valid = 1'b0; return; end
    for (int t = 0; t < 300; t++) begin
      int n;
      @(negedge clk);
      in_valid = 1'b0; pt = $urandom; key = {$urandom, $urandom};
      if (rand_ready) out_ready = 1'($urandom);
      ov = out_valid;
      if (ov) got = ct;
      @(posedge clk);
      n = t + 1;
      if (ov && !seen) begin seen = 1; lat = n; end
      if (ov && out_ready) return;
    end
    tmo = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; pt = KAT_PT; key = KAT_KEY;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, busy, round_idx, ct} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_state: got rdy=%b ov=%b busy=%b idx=%0d ct=%h, want rdy=1 ov=0 busy=0 idx=0 ct=0",
               in_ready, out_valid, busy, round_idx, ct);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_kat();
    logic [31:0] got; int lat; bit tmo;
    do_block(KAT_PT, KAT_KEY, 0, got, lat, tmo);
    tests++;
    if (tmo || got !== KAT_CT) begin
      fails++; $display("FAIL kat_ct: got %h (timeout=%0d), want %h", got, tmo, KAT_CT);
    end
    tests++;
    if (lat !== ROUNDS + 1) begin
      fails++; $display("FAIL kat_latency: got %0d, want %0d", lat, ROUNDS + 1);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || ct !== 32'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL kat_idle_after: got rdy=%b ct=%h busy=%b, want 1 0 0", in_ready, ct, busy);
    end
  endtask

  task automatic test_backpressure();
    bit bad = 0; bit found = 0;
    @(negedge clk);
    in_valid = 1'b1; pt = KAT_PT; key = KAT_KEY; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (out_valid) found = 1; else @(negedge clk);
    end
    tests++;
    if (!found) begin fails++; $display("FAIL bp_reach_done: got no out_valid, want out_valid"); end
    for (int t = 0; t < 10; t++) begin
      if (out_valid !== 1'b1 || ct !== KAT_CT || in_ready !== 1'b0) bad = 1;
      @(negedge clk);
    end
    tests++;
    if (bad) begin fails++; $display("FAIL bp_hold: output not held, want ov=1 ct=%h rdy=0 for 10 cycles", KAT_CT); end
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || ct !== KAT_CT) begin
      fails++; $display("FAIL bp_handshake: got ov=%b ct=%h, want 1 %h", out_valid, ct, KAT_CT);
    end
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bp_return_idle: got rdy=%b ov=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_reject();
    bit bad_idx = 0;
    @(negedge clk);
    in_valid = 1'b1; pt = KAT_PT; key = KAT_KEY; out_ready = 1'b1;
    @(posedge clk);
    for (int j = 0; j < ROUNDS; j++) begin
      @(negedge clk);
      in_valid = 1'(j % 3 == 0); pt = $urandom; key = {$urandom, $urandom};
      if (round_idx !== 5'(j) || busy !== 1'b1 || in_ready !== 1'b0) bad_idx = 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (bad_idx) begin fails++; $display("FAIL busy_round_idx: sequence wrong, want 0..%0d with busy=1", ROUNDS - 1); end
    tests++;
    if (out_valid !== 1'b1 || ct !== KAT_CT || round_idx !== 5'd0) begin
      fails++; $display("FAIL busy_result: got ov=%b ct=%h idx=%0d, want 1 %h 0", out_valid, ct, round_idx, KAT_CT);
    end
    @(negedge clk);
  endtask

  task automatic test_midrun_reset();
    bit hit = 0; bit spurious = 0;
    logic [31:0] got; int lat; bit tmo;
    @(negedge clk);
    in_valid = 1'b1; pt = KAT_PT; key = KAT_KEY; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      if (round_idx == 5'd10) hit = 1; else @(negedge clk);
    end
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (!hit || in_ready !== 1'b1 || busy !== 1'b0 || ct !== 32'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got hit=%0d rdy=%b busy=%b ct=%h ov=%b, want 1 1 0 0 0",
                        hit, in_ready, busy, ct, out_valid);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) spurious = 1;
    end
    tests++;
    if (spurious) begin fails++; $display("FAIL midrun_no_output: got out_valid after reset, want none"); end
    do_block(KAT_PT, KAT_KEY, 0, got, lat, tmo);
    tests++;
    if (tmo || got !== KAT_CT) begin
      fails++; $display("FAIL midrun_reissue: got %h (timeout=%0d), want %h", got, tmo, KAT_CT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa, pb; logic [63:0] ka, kb;
    int acc_cyc [2];
    logic [31:0] outs [2];
    int na = 0, no = 0;
    pa = $urandom; pb = $urandom; ka = {$urandom, $urandom}; kb = {$urandom, $urandom};
    @(negedge clk);
    in_valid = 1'b1; pt = pa; key = ka; out_ready = 1'b1;
    for (int t = 0; t < 120 && no < 2; t++) begin
      if (in_valid && in_ready && na < 2) begin
        acc_cyc[na] = cyc; na++;
        @(negedge clk);
        if (na == 1) begin pt = pb; key = kb; end else in_valid = 1'b0;
      end else begin
        if (out_valid && no < 2) begin outs[no] = ct; no++; end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (na != 2 || no != 2) begin
      fails++; $display("FAIL b2b_complete: got %0d accepts %0d outputs, want 2 2", na, no);
    end else begin
      tests++;
      if (acc_cyc[1] - acc_cyc[0] != ROUNDS + 2) begin
        fails++; $display("FAIL b2b_spacing: got %0d, want %0d", acc_cyc[1] - acc_cyc[0], ROUNDS + 2);
      end
      tests++;
      if (outs[0] !== speck_ref(pa, ka) || outs[1] !== speck_ref(pb, kb)) begin
        fails++; $display("FAIL b2b_ct: got %h %h, want %h %h", outs[0], outs[1], speck_ref(pa, ka), speck_ref(pb, kb));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] p, got, exp; logic [63:0] kk; int lat; bit tmo;
    for (int n = 0; n < 1000; n++) begin
      p = $urandom; kk = {$urandom, $urandom};
      exp = speck_ref(p, kk);
      do_block(p, kk, 1, got, lat, tmo);
      tests++;
      if (tmo || got !== exp || lat !== ROUNDS + 1) begin
        fails++;
        $display("FAIL random_%0d: got ct=%h lat=%0d tmo=%0d, want ct=%h lat=%0d", n, got, lat, tmo, exp, ROUNDS + 1);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = '0; key = '0;
    test_reset();
    test_kat();
    test_backpressure();
    test_busy_reject();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
